piso_serializer: RTL and testbench



---
 rtl/piso_serializer_pkg.sv | 20 ++
 rtl/piso_bit_counter.sv | 33 +++
 rtl/piso_serializer.sv | 107 ++++++++++
 tb/tb_piso_serializer.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/piso_serializer_pkg.sv
// Shared definitions for the parallel-in / serial-out transmitter.
//   state_t        : FSM encoding (IDLE / SHIFT)
//   DEFAULT_WIDTH  : default word width
//   cnt_width()    : bit-counter width for a given word width
package piso_serializer_pkg;

  localparam int DEFAULT_WIDTH = 4;
  localparam int DEFAULT_CNT_W = $clog2(DEFAULT_WIDTH);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // The counter must index bit positions 0..width-1.
  function automatic int cnt_width(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/piso_bit_counter.sv
// Bit-position counter for the serializer.
//   clk, rst    : clock, async active-low reset
//   clear       : synchronous return to 0 (has priority over enable)
//   enable      : advance by one
//   count       : current bit position
//   tc          : terminal count, high when count == WIDTH-1
module piso_bit_counter
  import piso_serializer_pkg::*;
#(
  parameter  int WIDTH = DEFAULT_WIDTH,
  localparam int CW    = cnt_width(WIDTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          enable,
  output logic [CW-1:0] count,
  output logic          tc
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

  assign tc = (count == CW'(WIDTH - 1));

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in, serial-out transmitter with valid/ready on both sides.
//   clk, rst               : clock, async active-low reset
//   load_valid/load_ready  : parallel word handshake, d sampled on accept
//   d                      : WIDTH-bit parallel word
//   s_valid/s_ready        : serial beat handshake
//   sdata                  : serial bit
//   sframe / slast         : first / last bit of a frame
//   busy                   : frame in progress
//
//   state | meaning
//   IDLE  | no frame, ready for a word, serial outputs low
//   SHIFT | frame in progress, shifting one bit per accepted beat
module piso_serializer
  import piso_serializer_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] d,
  input  logic             s_ready,
  output logic             s_valid,
  output logic             sdata,
  output logic             sframe,
  output logic             slast,
  output logic             busy
);

  localparam int CW = cnt_width(WIDTH);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q;
  logic [CW-1:0]    cnt;
  logic             tc;
  logic             load_fire;
  logic             beat;
  logic             out_bit;

  assign out_bit = (MSB_FIRST != 0) ? shreg_q[WIDTH-1] : shreg_q[0];

  piso_bit_counter #(.WIDTH(WIDTH)) u_cnt (
    .clk    (clk),
    .rst    (rst),
    // Returning to 0 on the final beat leaves the counter parked at 0 in IDLE.
    .clear  (load_fire || (beat && slast)),
    .enable (beat),
    .count  (cnt),
    .tc     (tc)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shreg_q <= '0;
    end else if (load_fire) begin
      shreg_q <= d;
    end else if (beat) begin
      if (MSB_FIRST != 0) begin
        shreg_q <= {shreg_q[WIDTH-2:0], 1'b0};
      end else begin
        shreg_q <= {1'b0, shreg_q[WIDTH-1:1]};
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    s_valid    = 1'b0;
    sdata      = 1'b0;
    sframe     = 1'b0;
    slast      = 1'b0;
    busy       = 1'b0;
    load_ready = 1'b0;
    case (state_q)
      IDLE: begin
        load_ready = rst;
      end
      SHIFT: begin
        s_valid    = 1'b1;
        busy       = 1'b1;
        sdata      = out_bit;
        sframe     = (cnt == '0);
        slast      = tc;
        // Only an accepted last beat frees the register for the next word.
        load_ready = rst && s_ready && tc;
      end
    endcase
    load_fire = load_valid && load_ready;
    beat      = s_valid && s_ready;
    if (load_fire) begin
      state_d = SHIFT;
    end else if (beat && slast) begin
      state_d = IDLE;
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Self-checking bench: two instances (MSB-first and LSB-first) share stimulus.
module tb_piso_serializer;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         load_valid = 1'b0;
  logic         s_ready = 1'b0;
  logic [W-1:0] d = '0;

  logic m_load_ready, m_s_valid, m_sdata, m_sframe, m_slast, m_busy;
  logic l_load_ready, l_s_valid, l_sdata, l_sframe, l_slast, l_busy;

  int n_checks = 0;
  int n_fail   = 0;
  int beats    = 0;

  typedef struct {
    logic [W-1:0] d;
    logic [W-1:0] seq_m;  // transmission order, bit 3 first
    logic [W-1:0] seq_l;
  } vec_t;

  typedef struct packed {
    logic b;
    logic f;
    logic l;
  } ent_t;

  vec_t vecs[4];
  ent_t qm[$];
  ent_t ql[$];

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(W), .MSB_FIRST(1)) dut_m (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(m_load_ready),
    .d(d), .s_ready(s_ready), .s_valid(m_s_valid), .sdata(m_sdata),
    .sframe(m_sframe), .slast(m_slast), .busy(m_busy)
  );

  piso_serializer #(.WIDTH(W), .MSB_FIRST(0)) dut_l (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(l_load_ready),
    .d(d), .s_ready(s_ready), .s_valid(l_s_valid), .sdata(l_sdata),
    .sframe(l_sframe), .slast(l_slast), .busy(l_busy)
  );

  always @(posedge clk) begin
    if (m_s_valid && s_ready) beats <= beats + 1;
  end

  task automatic chk(input string nm, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input logic v, input logic dm,
                         input logic dl, input logic fr, input logic la,
                         input logic lr);
    chk({tag, " m.s_valid"},    m_s_valid,    v);
    chk({tag, " m.busy"},       m_busy,       v);
    chk({tag, " m.sdata"},      m_sdata,      dm);
    chk({tag, " m.sframe"},     m_sframe,     fr);
    chk({tag, " m.slast"},      m_slast,      la);
    chk({tag, " m.load_ready"}, m_load_ready, lr);
    chk({tag, " l.s_valid"},    l_s_valid,    v);
    chk({tag, " l.busy"},       l_busy,       v);
    chk({tag, " l.sdata"},      l_sdata,      dl);
    chk({tag, " l.sframe"},     l_sframe,     fr);
    chk({tag, " l.slast"},      l_slast,      la);
    chk({tag, " l.load_ready"}, l_load_ready, lr);
  endtask

  // Frame d1, with load_valid/d2 presented from cycle start_k until the last beat.
  task automatic two_frames(input string tag, input logic [W-1:0] d1,
                            input logic [W-1:0] d2, input int start_k,
                            input logic [7:0] m_exp, input logic [7:0] l_exp);
    @(negedge clk);
    load_valid = 1'b1; d = d1; s_ready = 1'b1;
    @(negedge clk);
    for (int k = 1; k <= 8; k++) begin
      load_valid = (k >= start_k) && (k <= 4);
      d = d2;
      #1;
      chk_all($sformatf("%s k%0d", tag, k), 1'b1, m_exp[8-k], l_exp[8-k],
              (k == 1) || (k == 5), (k == 4) || (k == 8), (k == 4) || (k == 8));
      @(negedge clk);
    end
    load_valid = 1'b0;
    #1 chk_all({tag, " idle"}, 0, 0, 0, 0, 0, 1);
  endtask

  initial begin
    logic exp_v, exp_lr, em, el, ef, ea;
    int   beat_base;

    vecs[0] = '{d: 4'b1010, seq_m: 4'b1010, seq_l: 4'b0101};
    vecs[1] = '{d: 4'b1110, seq_m: 4'b1110, seq_l: 4'b0111};
    vecs[2] = '{d: 4'b0001, seq_m: 4'b0001, seq_l: 4'b1000};
    vecs[3] = '{d: 4'b1100, seq_m: 4'b1100, seq_l: 4'b0011};

    #2 chk_all("reset", 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b1;
    #1 chk_all("release", 0, 0, 0, 0, 0, 1);

    // Table-driven single frames with s_ready held high.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      load_valid = 1'b1; d = vecs[i].d; s_ready = 1'b1;
      #1 chk_all($sformatf("vec%0d load", i), 0, 0, 0, 0, 0, 1);
      @(negedge clk);
      load_valid = 1'b0; d = '0;
      for (int k = 0; k < 4; k++) begin
        #1 chk_all($sformatf("vec%0d b%0d", i, k), 1, vecs[i].seq_m[3-k],
                   vecs[i].seq_l[3-k], k == 0, k == 3, k == 3);
        @(negedge clk);
      end
      #1 chk_all($sformatf("vec%0d idle", i), 0, 0, 0, 0, 0, 1);
    end

    // Reset mid-frame with the counter at 2.
    @(negedge clk);
    load_valid = 1'b1; d = 4'b1010; s_ready = 1'b1;
    @(negedge clk);
    load_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1 chk_all("pre_rst", 1, 1, 0, 0, 0, 0);
    rst = 1'b0;
    #1 chk_all("async_rst", 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b1;
    #1 chk_all("rst_release", 0, 0, 0, 0, 0, 1);

    // Backpressure on bit 2 of 1110.
    @(negedge clk);
    beat_base = beats;
    load_valid = 1'b1; d = 4'b1110; s_ready = 1'b1;
    @(negedge clk);
    load_valid = 1'b0;
    #1 chk_all("bp b1", 1, 1, 0, 1, 0, 0);
    @(negedge clk);
    s_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1 chk_all($sformatf("bp stall%0d", k), 1, 1, 1, 0, 0, 0);
      @(negedge clk);
    end
    s_ready = 1'b1;
    #1 chk_all("bp b2", 1, 1, 1, 0, 0, 0);
    @(negedge clk);
    #1 chk_all("bp b3", 1, 1, 1, 0, 0, 0);
    @(negedge clk);
    #1 chk_all("bp b4", 1, 0, 1, 0, 1, 1);
    @(negedge clk);
    #1 chk_all("bp idle", 0, 0, 0, 0, 0, 1);
    n_checks++;
    if (beats - beat_base != 4) begin
      n_fail++;
      $display("FAIL bp beat count: got %0d expected 4", beats - beat_base);
    end

    two_frames("b2b",  4'b1010, 4'b1110, 1, 8'b1010_1110, 8'b0101_0111);
    two_frames("busy", 4'b1010, 4'b0001, 2, 8'b1010_0001, 8'b0101_1000);

    // Randomized phase against a queue-of-pending-bits reference model.
    qm.delete();
    ql.delete();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      load_valid = 1'($urandom);
      d          = 4'($urandom);
      s_ready    = ($urandom_range(0, 3) != 0);
      #1;
      exp_v  = (qm.size() != 0);
      exp_lr = (qm.size() == 0) || ((qm.size() == 1) && s_ready);
      em = 1'b0; el = 1'b0; ef = 1'b0; ea = 1'b0;
      if (exp_v) begin
        em = qm[0].b; el = ql[0].b; ef = qm[0].f; ea = qm[0].l;
      end
      chk_all($sformatf("rand%0d", cyc), exp_v, em, el, ef, ea, exp_lr);
      if (exp_v && s_ready) begin
        void'(qm.pop_front());
        void'(ql.pop_front());
      end
      if (load_valid && exp_lr) begin
        for (int i = 0; i < W; i++) begin
          qm.push_back('{b: d[W-1-i], f: (i == 0), l: (i == W-1)});
          ql.push_back('{b: d[i],     f: (i == 0), l: (i == W-1)});
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
